// File: rtl/sort_stream_rx.sv
// Serial receiver for sorted frames: detects frame start, deserializes
// MSB-first words into a register bank and checks non-decreasing order.
module sort_stream_rx #(
  parameter int WORD_W    = 4,
  parameter int NUM_WORDS = 8,
  parameter int IDX_W     = 3
) (
  input  logic              t_clk,
  input  logic              rst_n,
  input  logic              sort_finish,
  input  logic              data_in,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              frame_done,
  output logic              frame_valid,
  output logic              order_err,
  output logic [IDX_W-1:0]  err_index,
  output logic              abort
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic               prev_sf;
  logic [BIT_W-1:0]   bit_cnt;
  logic [IDX_W-1:0]   word_cnt;
  logic [WORD_W-2:0]  sr;
  logic [WORD_W-1:0]  prev_word;
  logic [WORD_W-1:0]  word;
  logic [WORD_W-1:0]  bank [NUM_WORDS];

  // The word completes on the same edge its last bit arrives.
  always_comb word = {sr, data_in};

  assign rd_data = bank[rd_addr];

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prev_sf     <= 1'b0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      sr          <= '0;
      prev_word   <= '0;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      order_err   <= 1'b0;
      err_index   <= '0;
      abort       <= 1'b0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) bank[i] <= '0;
    end else begin
      prev_sf    <= sort_finish;
      frame_done <= 1'b0;
      abort      <= 1'b0;
      case (state)
        IDLE: begin
          if (sort_finish && !prev_sf) begin
            state       <= SHIFT;
            order_err   <= 1'b0;
            err_index   <= '0;
            frame_valid <= 1'b0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
          end
        end
        SHIFT: begin
          if (!sort_finish) begin
            // Truncated frame: partial word is dropped, stored words are kept.
            state <= IDLE;
            abort <= 1'b1;
          end else begin
            sr      <= word[WORD_W-2:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_W'(WORD_W - 1)) begin
              bit_cnt         <= '0;
              bank[word_cnt]  <= word;
              prev_word       <= word;
              word_cnt        <= word_cnt + 1'b1;
              if (word_cnt != '0 && word < prev_word && !order_err) begin
                order_err <= 1'b1;
                err_index <= word_cnt;
              end
              if (word_cnt == IDX_W'(NUM_WORDS - 1)) begin
                state       <= DONE;
                frame_done  <= 1'b1;
                frame_valid <= 1'b1;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_stream_rx.sv
// Directed bench for sort_stream_rx: sorted, unsorted, aborted, reset and
// back-to-back frames with hand-computed expectations.
module tb_sort_stream_rx;

  logic       t_clk = 1'b0;
  logic       rst_n;
  logic       sort_finish;
  logic       data_in;
  logic [2:0] rd_addr;
  logic [3:0] rd_data;
  logic       frame_done;
  logic       frame_valid;
  logic       order_err;
  logic [2:0] err_index;
  logic       abort;

  int checks = 0;
  int errors = 0;

  sort_stream_rx #(.WORD_W(4), .NUM_WORDS(8), .IDX_W(3)) dut (
    .t_clk       (t_clk),
    .rst_n       (rst_n),
    .sort_finish (sort_finish),
    .data_in     (data_in),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_done  (frame_done),
    .frame_valid (frame_valid),
    .order_err   (order_err),
    .err_index   (err_index),
    .abort       (abort)
  );

  always #5 t_clk = ~t_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [3:0] exp);
    rd_addr = a;
    #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  // Raise sort_finish, take the start edge, then stream n bits MSB-first.
  task automatic start_send(input logic [31:0] bits, input int n);
    @(negedge t_clk);
    sort_finish = 1'b1;
    @(posedge t_clk);
    #1;
    chk("start_clr_err", 32'(order_err), 32'h0);
    chk("start_clr_valid", 32'(frame_valid), 32'h0);
    chk("start_clr_idx", 32'(err_index), 32'h0);
    for (int i = 0; i < n; i++) begin
      @(negedge t_clk);
      data_in = bits[31-i];
    end
  endtask

  task automatic full_frame(input string tag, input logic [31:0] bits,
                            input logic exp_err, input logic [2:0] exp_idx);
    start_send(bits, 32);
    chk({tag, "_done_early"}, 32'(frame_done), 32'h0);
    @(posedge t_clk);
    #1;
    chk({tag, "_done"}, 32'(frame_done), 32'h1);
    chk({tag, "_valid"}, 32'(frame_valid), 32'h1);
    chk({tag, "_err"}, 32'(order_err), 32'(exp_err));
    chk({tag, "_idx"}, 32'(err_index), 32'(exp_idx));
    @(posedge t_clk);
    #1;
    chk({tag, "_done_1cyc"}, 32'(frame_done), 32'h0);
    chk({tag, "_valid_hold"}, 32'(frame_valid), 32'h1);
  endtask

  task automatic drop_sf;
    @(negedge t_clk);
    sort_finish = 1'b0;
    @(posedge t_clk);
    #1;
  endtask

  initial begin
    int pulses;
    rst_n       = 1'b0;
    sort_finish = 1'b0;
    data_in     = 1'b0;
    rd_addr     = 3'd0;
    #1;
    chk("rst_done", 32'(frame_done), 32'h0);
    chk("rst_valid", 32'(frame_valid), 32'h0);
    chk("rst_err", 32'(order_err), 32'h0);
    chk("rst_idx", 32'(err_index), 32'h0);
    chk("rst_abort", 32'(abort), 32'h0);
    chk("rst_rd", 32'(rd_data), 32'h0);
    repeat (2) @(negedge t_clk);
    rst_n = 1'b1;
    @(posedge t_clk);
    #1;

    // 1: sorted frame with equal neighbours
    full_frame("t1", 32'h0122_4555, 1'b0, 3'd0);
    rd_chk("t1_rd3", 3'd3, 4'h2);
    rd_chk("t1_rd7", 3'd7, 4'h5);
    drop_sf();

    // 2: first drop at word 4
    full_frame("t2", 32'hCDEF_CDEF, 1'b1, 3'd4);
    rd_chk("t2_rd7", 3'd7, 4'hF);
    drop_sf();

    // 3: only the first drop is reported
    full_frame("t3", 32'hEDE1_87AF, 1'b1, 3'd1);
    rd_chk("t3_rd3", 3'd3, 4'h1);
    drop_sf();

    // 4: abort after 13 bits; word 3 keeps frame 3's value
    start_send(32'h333F_0000, 13);
    @(negedge t_clk);
    sort_finish = 1'b0;
    @(posedge t_clk);
    #1;
    chk("t4_abort", 32'(abort), 32'h1);
    chk("t4_valid", 32'(frame_valid), 32'h0);
    chk("t4_nodone", 32'(frame_done), 32'h0);
    @(posedge t_clk);
    #1;
    chk("t4_abort_1cyc", 32'(abort), 32'h0);
    rd_chk("t4_rd0", 3'd0, 4'h3);
    rd_chk("t4_rd2", 3'd2, 4'h3);
    rd_chk("t4_rd3", 3'd3, 4'h1);
    full_frame("t4b", 32'h0123_4567, 1'b0, 3'd0);
    rd_chk("t4b_rd5", 3'd5, 4'h5);
    drop_sf();

    // 5: reset after 20 bits of a frame that already has an order error
    start_send(32'hF000_0000, 20);
    #2;
    chk("t5_pre_err", 32'(order_err), 32'h1);
    rst_n       = 1'b0;
    sort_finish = 1'b0;
    rd_addr     = 3'd0;
    #1;
    chk("t5_err", 32'(order_err), 32'h0);
    chk("t5_idx", 32'(err_index), 32'h0);
    chk("t5_valid", 32'(frame_valid), 32'h0);
    chk("t5_rd0", 32'(rd_data), 32'h0);
    rd_chk("t5_rd7", 3'd7, 4'h0);
    @(negedge t_clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge t_clk);
      #1;
      if (frame_done || abort) pulses++;
    end
    chk("t5_no_pulse", 32'(pulses), 32'h0);

    // 6: back-to-back, erroneous then sorted, then held-high sort_finish
    full_frame("t6a", 32'hCDEF_CDEF, 1'b1, 3'd4);
    @(negedge t_clk);
    sort_finish = 1'b0;
    full_frame("t6b", 32'h1111_2233, 1'b0, 3'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge t_clk);
      #1;
      if (frame_done || abort || !frame_valid) pulses++;
    end
    chk("t6_no_retrig", 32'(pulses), 32'h0);
    rd_chk("t6_rd7", 3'd7, 4'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
